// File: rtl/instr_register_pipe_pkg.sv
// Shared types and defaults for the instruction register pipeline.
// The opcode enum covers the eight legal encodings; 8-15 are illegal.
package instr_register_pkg;

  localparam int OPC_W         = 4;
  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_OP_W  = 32;

  typedef enum logic [OPC_W-1:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

endpackage

// File: rtl/instr_register_pipe_if.sv
// Write port, read request and read result bundle for instr_register_pipe.
// The slave modport is the register side; master is the driver/checker side.
interface instr_register_pipe_if #(
  parameter int DEPTH = instr_register_pkg::DEFAULT_DEPTH,
  parameter int OP_W  = instr_register_pkg::DEFAULT_OP_W
);
  import instr_register_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);

  logic                     load_en;
  logic [ADDR_W-1:0]        write_pointer;
  opcode_t                  opcode;
  logic signed [OP_W-1:0]   operand_a;
  logic signed [OP_W-1:0]   operand_b;
  logic                     rd_req;
  logic [ADDR_W-1:0]        read_pointer;
  logic                     rd_valid;
  opcode_t                  rd_opcode;
  logic signed [OP_W-1:0]   rd_operand_a;
  logic signed [OP_W-1:0]   rd_operand_b;
  logic signed [2*OP_W-1:0] rd_result;
  logic                     rd_err;
  logic                     rd_div_zero;
  logic [ADDR_W:0]          entry_count;

  modport slave (
    input  load_en, write_pointer, opcode, operand_a, operand_b, rd_req, read_pointer,
    output rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_err,
           rd_div_zero, entry_count
  );

  modport master (
    output load_en, write_pointer, opcode, operand_a, operand_b, rd_req, read_pointer,
    input  rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_err,
           rd_div_zero, entry_count
  );

endinterface

// File: rtl/instr_register_pipe_alu.sv
// Combinational ALU: operands are sign-extended to 2*OP_W, so ADD/SUB/MULT
// never overflow. DIV truncates toward zero, MOD follows the dividend sign.
module instr_alu import instr_register_pkg::*; #(
  parameter int OP_W = DEFAULT_OP_W
) (
  input  opcode_t                  opcode_i,
  input  logic signed [OP_W-1:0]   a_i,
  input  logic signed [OP_W-1:0]   b_i,
  output logic signed [2*OP_W-1:0] result_o,
  output logic                     div_zero_o,
  output logic                     illegal_o
);

  localparam int RW = 2 * OP_W;

  logic signed [RW-1:0] a_x;
  logic signed [RW-1:0] b_x;

  assign a_x = {{OP_W{a_i[OP_W-1]}}, a_i};
  assign b_x = {{OP_W{b_i[OP_W-1]}}, b_i};

  always_comb begin
    result_o   = '0;
    div_zero_o = 1'b0;
    illegal_o  = 1'b0;
    case (opcode_i)
      ZERO:  result_o = '0;
      PASSA: result_o = a_x;
      PASSB: result_o = b_x;
      ADD:   result_o = a_x + b_x;
      SUB:   result_o = a_x - b_x;
      MULT:  result_o = a_x * b_x;
      DIV: begin
        if (b_i == '0) div_zero_o = 1'b1;
        else           result_o   = a_x / b_x;
      end
      MOD: begin
        if (b_i == '0) div_zero_o = 1'b1;
        else           result_o   = a_x % b_x;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_register_pipe.sv
// DEPTH-entry instruction store with a 2-stage read/execute pipeline.
// Stage 1 latches the addressed entry, stage 2 registers the ALU result.
module instr_register_pipe import instr_register_pkg::*; #(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int OP_W  = DEFAULT_OP_W
) (
  input logic                  clk,
  input logic                  reset,
  instr_register_pipe_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef struct packed {
    opcode_t                opcode;
    logic signed [OP_W-1:0] a;
    logic signed [OP_W-1:0] b;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [ADDR_W:0]  count_q;
  logic [ADDR_W:0]  count_d;

  logic   s1_req_q;
  entry_t s1_entry_q;
  logic   s1_written_q;

  logic                     rd_valid_q;
  entry_t                   rd_entry_q;
  logic signed [2*OP_W-1:0] rd_result_q;
  logic signed [2*OP_W-1:0] rd_result_d;
  logic                     rd_err_q;
  logic                     rd_err_d;
  logic                     rd_div_zero_q;
  logic                     rd_div_zero_d;

  logic signed [2*OP_W-1:0] alu_result;
  logic                     alu_div_zero;
  logic                     alu_illegal;

  always_comb begin
    count_d = count_q;
    if (bus.load_en && !valid_q[bus.write_pointer]) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      valid_q <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (bus.load_en) begin
        mem_q[bus.write_pointer]   <= '{opcode: bus.opcode, a: bus.operand_a, b: bus.operand_b};
        valid_q[bus.write_pointer] <= 1'b1;
      end
    end
  end

  // Stage 1 samples the pre-write contents, giving read-before-write on collisions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_req_q     <= 1'b0;
      s1_entry_q   <= '0;
      s1_written_q <= 1'b0;
    end else begin
      s1_req_q <= bus.rd_req;
      if (bus.rd_req) begin
        s1_entry_q   <= mem_q[bus.read_pointer];
        s1_written_q <= valid_q[bus.read_pointer];
      end
    end
  end

  instr_alu #(.OP_W(OP_W)) u_alu (
    .opcode_i   (s1_entry_q.opcode),
    .a_i        (s1_entry_q.a),
    .b_i        (s1_entry_q.b),
    .result_o   (alu_result),
    .div_zero_o (alu_div_zero),
    .illegal_o  (alu_illegal)
  );

  always_comb begin
    rd_result_d   = '0;
    rd_err_d      = 1'b1;
    rd_div_zero_d = 1'b0;
    if (s1_written_q) begin
      rd_result_d   = alu_result;
      rd_err_d      = alu_illegal;
      rd_div_zero_d = alu_div_zero;
    end
  end

  // Output data only moves on a valid stage-1 slot, so it holds between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q    <= 1'b0;
      rd_entry_q    <= '0;
      rd_result_q   <= '0;
      rd_err_q      <= 1'b0;
      rd_div_zero_q <= 1'b0;
    end else begin
      rd_valid_q <= s1_req_q;
      if (s1_req_q) begin
        rd_entry_q    <= s1_entry_q;
        rd_result_q   <= rd_result_d;
        rd_err_q      <= rd_err_d;
        rd_div_zero_q <= rd_div_zero_d;
      end
    end
  end

  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_opcode    = rd_entry_q.opcode;
  assign bus.rd_operand_a = rd_entry_q.a;
  assign bus.rd_operand_b = rd_entry_q.b;
  assign bus.rd_result    = rd_result_q;
  assign bus.rd_err       = rd_err_q;
  assign bus.rd_div_zero  = rd_div_zero_q;
  assign bus.entry_count  = count_q;

endmodule
